// File: rtl/fsm_scenario_monitor_pkg.sv
// Shared types and helpers for the scenario generator / monitor pair.
package fsm_scenario_monitor_pkg;

   typedef struct packed {
      logic [7:0] scenario_state;
   } output_signals_t;

   typedef enum logic [3:0] {
      SCN_IDLE              = 4'd0,
      SCN_POWER_UP          = 4'd1,
      SCN_CALIBRATE         = 4'd2,
      SCN_INJECT_PULSE      = 4'd3,
      SCN_WAIT_RESPONSE     = 4'd4,
      SCN_CAPTURE           = 4'd5,
      SCN_COMPARE           = 4'd6,
      SCN_REPORT            = 4'd7,
      SCN_DETECTOR_FINISHED = 4'd8
   } scenario_code_e;

   localparam logic [3:0] SCN_LAST = 4'd8;

   typedef enum logic [1:0] {
      M_OFF,
      M_SYNC,
      M_TRACK,
      M_FAIL
   } monitor_state_e;

   // Legal successor of a scenario code; the last code wraps back to IDLE.
   function automatic logic [3:0] scn_next(input logic [3:0] code);
      return (code >= SCN_LAST) ? 4'd0 : code + 4'd1;
   endfunction

   function automatic logic scn_out_of_range(input logic [7:0] code);
      return (code[7:4] != 4'd0) || (code[3:0] > SCN_LAST);
   endfunction

endpackage

// File: rtl/fsm_scenario_monitor_dwell.sv
// Dwell counter: reloads to 1 on a code change, otherwise counts up and
// saturates one past the allowed maximum so the overrun stays visible.
module scn_dwell_counter
   import fsm_scenario_monitor_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DWELL_MIN = 900,
   parameter int unsigned DWELL_MAX = 1100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic reload_i,
   output logic ge_min_o,
   output logic over_max_o
);

   localparam logic [CNT_W-1:0] SAT_V = CNT_W'(DWELL_MAX + 1);
   localparam logic [CNT_W-1:0] MIN_V = CNT_W'(DWELL_MIN);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear, reload on change, else saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (reload_i) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != SAT_V) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign ge_min_o   = (cnt_q >= MIN_V);
   assign over_max_o = (cnt_q == SAT_V);

endmodule

// File: rtl/fsm_scenario_monitor.sv
// Receiving-end checker for the self-test scenario sequence: ordering,
// dwell time and code range, with sticky errors and loop statistics.
module fsm_scenario_monitor
   import fsm_scenario_monitor_pkg::*;
#(
   parameter int unsigned DWELL_MIN = 900,
   parameter int unsigned DWELL_MAX = 1100,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             clear,
   input  logic [7:0]       scenario_state,
   output logic             busy,
   output logic             seq_error,
   output logic             timeout_error,
   output logic [3:0]       err_code,
   output logic [3:0]       expected,
   output logic             loop_done,
   output logic [CNT_W-1:0] loop_count,
   output logic [3:0]       step
);

   monitor_state_e   state_q, state_d;
   logic [7:0]       cur_q, prev_q;
   logic [3:0]       step_q, step_d, expected_q, expected_d, err_code_q, err_code_d;
   logic             seq_error_q, seq_error_d, timeout_error_q, timeout_error_d;
   logic             loop_done_q, loop_done_d;
   logic [CNT_W-1:0] loop_count_q, loop_count_d;
   logic             change, ge_min, over_max, first_err;

   assign change    = (cur_q != prev_q);
   assign first_err = !seq_error_q && !timeout_error_q;

   scn_dwell_counter #(
      .CNT_W     (CNT_W),
      .DWELL_MIN (DWELL_MIN),
      .DWELL_MAX (DWELL_MAX)
   ) u_dwell (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .clr_i      (clear),
      .reload_i   (change),
      .ge_min_o   (ge_min),
      .over_max_o (over_max)
   );

   // Input pipeline: current and previous code for change detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_q  <= '0;
         prev_q <= '0;
      end else begin
         cur_q  <= scenario_state;
         prev_q <= cur_q;
      end
   end

   // Monitor next-state and output logic; clear outranks every other event.
   always_comb begin
      state_d         = state_q;
      step_d          = step_q;
      expected_d      = expected_q;
      err_code_d      = err_code_q;
      seq_error_d     = seq_error_q;
      timeout_error_d = timeout_error_q;
      loop_done_d     = 1'b0;
      loop_count_d    = loop_count_q;
      if (clear) begin
         seq_error_d     = 1'b0;
         timeout_error_d = 1'b0;
         err_code_d      = '0;
         loop_count_d    = '0;
         step_d          = SCN_IDLE;
         expected_d      = 4'd1;
         state_d         = enable ? M_SYNC : M_OFF;
      end else if (!enable) begin
         state_d = M_OFF;
         if (state_q != M_OFF) begin
            step_d     = SCN_IDLE;
            expected_d = 4'd1;
         end
      end else begin
         case (state_q)
            M_OFF: state_d = M_SYNC;
            M_SYNC: begin
               if (cur_q == 8'd0) begin
                  state_d    = M_TRACK;
                  step_d     = SCN_IDLE;
                  expected_d = 4'd1;
               end
            end
            M_TRACK: begin
               if (change) begin
                  if (scn_out_of_range(cur_q) || (cur_q[3:0] != expected_q) ||
                      ((step_q != SCN_IDLE) && !ge_min)) begin
                     seq_error_d = 1'b1;
                     if (first_err) err_code_d = cur_q[3:0];
                     state_d = M_FAIL;
                  end else begin
                     step_d     = cur_q[3:0];
                     expected_d = scn_next(cur_q[3:0]);
                     if (step_q == SCN_LAST) begin
                        loop_done_d = 1'b1;
                        if (loop_count_q != '1) loop_count_d = loop_count_q + CNT_W'(1);
                     end
                  end
               end else if ((step_q != SCN_IDLE) && over_max) begin
                  timeout_error_d = 1'b1;
                  if (first_err) err_code_d = step_q;
                  state_d = M_FAIL;
               end
            end
            M_FAIL: state_d = M_FAIL;
            default: state_d = M_OFF;
         endcase
      end
   end

   // Monitor state and status registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= M_OFF;
         step_q          <= '0;
         expected_q      <= '0;
         err_code_q      <= '0;
         seq_error_q     <= 1'b0;
         timeout_error_q <= 1'b0;
         loop_done_q     <= 1'b0;
         loop_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         step_q          <= step_d;
         expected_q      <= expected_d;
         err_code_q      <= err_code_d;
         seq_error_q     <= seq_error_d;
         timeout_error_q <= timeout_error_d;
         loop_done_q     <= loop_done_d;
         loop_count_q    <= loop_count_d;
      end
   end

   assign busy          = (state_q == M_SYNC) || (state_q == M_TRACK);
   assign seq_error     = seq_error_q;
   assign timeout_error = timeout_error_q;
   assign err_code      = err_code_q;
   assign expected      = expected_q;
   assign loop_done     = loop_done_q;
   assign loop_count    = loop_count_q;
   assign step          = step_q;

endmodule

// File: tb/tb_fsm_scenario_monitor.sv
// Directed bench for fsm_scenario_monitor with short dwell limits.
`timescale 1ns/1ps
module tb_fsm_scenario_monitor;

   localparam int unsigned DMIN = 4;
   localparam int unsigned DMAX = 8;
   localparam int unsigned CW   = 16;

   logic          clock, reset_n, enable, clear;
   logic [7:0]    scenario_state;
   logic          busy, seq_error, timeout_error, loop_done;
   logic [3:0]    err_code, expected, step;
   logic [CW-1:0] loop_count;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   typedef struct {
      bit          rst;
      logic [7:0]  code;
      int unsigned hold;
      logic [3:0]  step;
      logic [3:0]  expct;
      logic        busy;
      logic        seq;
      logic        tmo;
      logic [3:0]  ecode;
      logic [15:0] lcount;
   } vec_t;

   vec_t tbl[$];

   fsm_scenario_monitor #(
      .DWELL_MIN (DMIN),
      .DWELL_MAX (DMAX),
      .CNT_W     (CW)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable         (enable),
      .clear          (clear),
      .scenario_state (scenario_state),
      .busy           (busy),
      .seq_error      (seq_error),
      .timeout_error  (timeout_error),
      .err_code       (err_code),
      .expected       (expected),
      .loop_done      (loop_done),
      .loop_count     (loop_count),
      .step           (step)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(negedge clock) if (loop_done === 1'b1) pulses++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t v(bit r, logic [7:0] c, int unsigned h, logic [3:0] s,
                              logic [3:0] e, logic b, logic sq, logic tm,
                              logic [3:0] ec, logic [15:0] lc);
      vec_t x;
      x.rst = r; x.code = c; x.hold = h; x.step = s; x.expct = e;
      x.busy = b; x.seq = sq; x.tmo = tm; x.ecode = ec; x.lcount = lc;
      return x;
   endfunction

   // Drive a code and keep it for n sampling edges; returns #1 after the last.
   task automatic hold(input logic [7:0] code, input int unsigned n);
      scenario_state = code;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; enable = 1'b0; clear = 1'b0; scenario_state = 8'h00;
      #12;
      chk("rst busy", 32'(busy), 0);
      chk("rst errs", {30'd0, seq_error, timeout_error}, 0);
      chk("rst step/exp/ecode", {20'd0, step, expected, err_code}, 0);
      chk("rst loop", {15'd0, loop_done, loop_count}, 0);
      @(negedge clock);
      reset_n = 1'b1; enable = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic run_loop(input int unsigned h);
      for (int unsigned k = 1; k <= 8; k++) hold(8'(k), h);
      hold(8'h00, h);
   endtask

   initial begin
      int p0;
      reset_n = 1'b0; enable = 1'b0; clear = 1'b0; scenario_state = 8'h00;

      // Clean loop 0,1..8,0.
      tbl.push_back(v(1, 8'd0, 6, 4'd0, 4'd1, 1, 0, 0, 4'd0, 16'd0));
      for (int unsigned k = 1; k <= 8; k++)
         tbl.push_back(v(0, 8'(k), 6, 4'(k), (k == 8) ? 4'd0 : 4'(k + 1), 1, 0, 0, 4'd0, 16'd0));
      tbl.push_back(v(0, 8'd0, 6, 4'd0, 4'd1, 1, 0, 0, 4'd0, 16'd1));
      // Skipped code 3: error freezes status, later codes ignored.
      tbl.push_back(v(1, 8'd0, 6, 4'd0, 4'd1, 1, 0, 0, 4'd0, 16'd0));
      tbl.push_back(v(0, 8'd1, 6, 4'd1, 4'd2, 1, 0, 0, 4'd0, 16'd0));
      tbl.push_back(v(0, 8'd2, 6, 4'd2, 4'd3, 1, 0, 0, 4'd0, 16'd0));
      tbl.push_back(v(0, 8'd4, 6, 4'd2, 4'd3, 0, 1, 0, 4'd4, 16'd0));
      tbl.push_back(v(0, 8'd5, 6, 4'd2, 4'd3, 0, 1, 0, 4'd4, 16'd0));

      p0 = pulses;
      for (int unsigned i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         hold(tbl[i].code, tbl[i].hold);
         chk($sformatf("v%0d step", i), 32'(step), 32'(tbl[i].step));
         chk($sformatf("v%0d expected", i), 32'(expected), 32'(tbl[i].expct));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("v%0d seq_error", i), 32'(seq_error), 32'(tbl[i].seq));
         chk($sformatf("v%0d timeout_error", i), 32'(timeout_error), 32'(tbl[i].tmo));
         chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(tbl[i].ecode));
         chk($sformatf("v%0d loop_count", i), 32'(loop_count), 32'(tbl[i].lcount));
      end
      chk("table loop_done pulses", 32'(pulses - p0), 1);

      // Timeout on code 5; code 4 held exactly DWELL_MIN cycles is legal.
      do_reset();
      hold(8'd0, 6);
      for (int unsigned k = 1; k <= 3; k++) hold(8'(k), 6);
      hold(8'd4, 4);
      hold(8'd5, 10);
      chk("dwell min boundary seq", 32'(seq_error), 0);
      chk("tmo not yet", 32'(timeout_error), 0);
      hold(8'd5, 1);
      chk("tmo fired", 32'(timeout_error), 1);
      chk("tmo err_code", 32'(err_code), 5);
      chk("tmo seq clear", 32'(seq_error), 0);
      chk("tmo busy", 32'(busy), 0);

      // Code 2 left after 3 cycles.
      do_reset();
      hold(8'd0, 6); hold(8'd1, 6); hold(8'd2, 3); hold(8'd3, 6);
      chk("early seq", 32'(seq_error), 1);
      chk("early err_code", 32'(err_code), 3);
      chk("early tmo", 32'(timeout_error), 0);

      // Out-of-range code, then clear and a fresh loop.
      do_reset();
      hold(8'd0, 6); hold(8'd1, 6); hold(8'h1A, 6);
      chk("range seq", 32'(seq_error), 1);
      chk("range err_code", 32'(err_code), 32'hA);
      scenario_state = 8'h00; clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      chk("clear errs", {30'd0, seq_error, timeout_error}, 0);
      chk("clear err_code", 32'(err_code), 0);
      chk("clear busy", 32'(busy), 1);
      hold(8'd0, 6);
      p0 = pulses;
      run_loop(6);
      chk("post-clear loop_count", 32'(loop_count), 1);
      chk("post-clear errs", {30'd0, seq_error, timeout_error}, 0);
      chk("post-clear pulses", 32'(pulses - p0), 1);

      // Two loops, async reset at code 4, then a fresh loop.
      do_reset();
      hold(8'd0, 6);
      run_loop(6);
      run_loop(6);
      chk("two loops", 32'(loop_count), 2);
      for (int unsigned k = 1; k <= 3; k++) hold(8'(k), 6);
      hold(8'd4, 2);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async rst busy", 32'(busy), 0);
      chk("async rst loop_count", 32'(loop_count), 0);
      chk("async rst step/exp", {24'd0, step, expected}, 0);
      p0 = pulses;
      do_reset();
      hold(8'd0, 6);
      run_loop(6);
      chk("after rst loop_count", 32'(loop_count), 1);
      chk("after rst pulses", 32'(pulses - p0), 1);

      // Enable dropped mid-run: counters kept, tracking reset.
      hold(8'd1, 6);
      enable = 1'b0;
      @(posedge clock); #1;
      chk("disable busy", 32'(busy), 0);
      chk("disable loop_count", 32'(loop_count), 1);
      chk("disable step", 32'(step), 0);
      chk("disable expected", 32'(expected), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_scenario_monitor.md
Name: fsm_scenario_monitor

Overview:
- Receiving-end checker for the self-test scenario generator.
- Watches the 8-bit scenario_state code carried in output_signals_t and checks three things: legal state ordering, per-state dwell time and code range.
- Reports sticky errors, a completed-loop pulse and loop/step counters for the status readout.
- Sits in the sync block next to the self-test FSM; it is the in-hardware verdict on the scenario sequence.

Parameters:
- DWELL_MIN, 900: minimum clock cycles a non-IDLE state must be held.
- DWELL_MAX, 1100: maximum clock cycles a non-IDLE state may be held.
- CNT_W, 16: width of the dwell counter and loop counter. Must satisfy 2^CNT_W > DWELL_MAX+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  monitor run enable; low forces M_OFF.
- clear  in  1  synchronous clear of sticky errors and counters.
- scenario_state  in  8  scenario code, same clock domain. Legal codes: 0=IDLE … 8=DETECTOR_FINISHED.
- busy  out  1  high in M_SYNC or M_TRACK.
- seq_error  out  1  sticky; illegal transition, out-of-range code, or a state left too early.
- timeout_error  out  1  sticky; a state was held longer than DWELL_MAX.
- err_code  out  4  code present when the first error latched; frozen until clear.
- expected  out  4  next legal code.
- loop_done  out  1  one-cycle pulse on a completed 0→1→…→8→0 loop.
- loop_count  out  CNT_W  completed loops; saturates at all-ones.
- step  out  4  current tracked code.

Behaviour:
- Reset (async, reset_n low): all outputs 0, monitor state M_OFF, dwell_cnt 0.
- Input register: scenario_state is registered into cur_q each cycle, and cur_q is copied to prev_q.
- Change event: cur_q != prev_q.
- Latency: a code appearing at the input in cycle N produces an error flag or loop_done registered at edge N+2.
- Code checks:
  - Out of range: cur_q[7:4] != 0 or cur_q[3:0] > 8.
  - Legal successor: (prev+1), with 8 wrapping to 0.
- Dwell counter:
  - Reloads to 1 on each change event.
  - Otherwise increments, saturating at DWELL_MAX+1.
  - Ignored while step == IDLE.
- Monitor FSM:
  - M_OFF: enable=1 → M_SYNC.
  - M_SYNC: wait for cur_q == 0 → M_TRACK with step=0, expected=1. Non-zero codes are ignored here (no error).
  - M_TRACK, on a change event:
    - Out-of-range code → seq_error, M_FAIL.
    - cur_q != expected → seq_error, M_FAIL.
    - Leaving a non-IDLE state with dwell_cnt < DWELL_MIN → seq_error, M_FAIL.
    - Otherwise step=cur_q and expected advances, wrapping 8→0.
    - Transition 8→0 → loop_done pulse and loop_count+1.
  - M_TRACK, no change: step != IDLE and dwell_cnt == DWELL_MAX+1 → timeout_error, M_FAIL.
  - M_FAIL: hold all error outputs. Only clear or enable=0 leaves this state.
- Error precedence: on the first error, err_code captures cur_q[3:0] (or step on timeout). Later errors do not overwrite it.
- If seq_error and timeout_error would fire in the same cycle, seq_error wins and timeout_error stays 0.
- clear:
  - Zeros errors, err_code, loop_count and dwell_cnt.
  - Next state is M_SYNC if enable=1, else M_OFF.
  - Has priority over any same-cycle event; that event is discarded.
- enable falling mid-run: next cycle M_OFF, busy=0. Sticky errors and loop_count are retained; step and expected reset to 0 and 1.
- Async reset mid-run: immediate return to reset values; no pulse is emitted.
- loop_count saturates and never wraps.

Decomposition:
- Shared package (alongside output_signals_t):
  - scenario_code_e: 0..8, with the same names as the generator states.
  - SCN_LAST = 8.
  - monitor_state_e {M_OFF, M_SYNC, M_TRACK, M_FAIL}.
  - Function scn_next(code) implementing the 8→0 wrap.
- One sub-module, scn_dwell_counter: reload/increment/saturate counter with CNT_W and DWELL_MAX parameters. It exposes ge_min and over_max flags.

Test Plan (DWELL_MIN=4, DWELL_MAX=8 for the bench):
- Reset, enable=1, drive 0 then 1..8,0 each held 6 cycles → loop_done pulses once, loop_count=1, both errors 0.
- Loop as above, but skip code 3 (2→4) → seq_error=1, err_code=4, expected=3; later codes are ignored.
- Hold code 5 for 9 cycles → timeout_error=1 at dwell 9, err_code=5, seq_error=0.
- Leave code 2 after 3 cycles → seq_error=1, err_code=3.
- Drive 0x1A in M_TRACK → seq_error=1, err_code=0xA. Then assert clear with enable=1 → errors 0, M_SYNC, busy=1; a fresh loop passes.
- Two loops, then reset_n low mid-loop (at code 4) → all outputs 0 immediately. After release a fresh loop gives loop_count=1.
